seq_code_lock: RTL and testbench
================================

SEQ_CODE_LOCK -- requirements
Module: seq_code_lock

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, bits per code digit.
REQ-002 SHALL have parameter N_DIGITS, default 4, digits per code (>=1).
REQ-003 SHALL have parameter PASSCODE, default 16'h9317, DIGIT_W*N_DIGITS bits; digit 0 in the MS digit.
REQ-004 SHALL have parameter MAX_TRIES, default 3, failed codes before lockout (>=1).
REQ-005 SHALL have parameter LOCKOUT_CYC, default 100_000_000, lockout length in clk cycles (>=1).
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port enter  input  1  single-cycle pulse, submit current digit (pre-debounced upstream).
REQ-009 SHALL have port oops  input  1  single-cycle pulse, clear entry / relock.
REQ-010 SHALL have port login  input  DIGIT_W  digit value, sampled when enter=1.
REQ-011 SHALL have port loginled  output  DIGIT_W  combinational copy of login.
REQ-012 SHALL have port flag  output  4  registered state indication: [0] ENTRY, [1] ERROR, [2] LOCKOUT, [3] OPEN; exactly one bit set.
REQ-013 SHALL have port digit_cnt  output  clog2(N_DIGITS+1)  digits entered in the current attempt.
REQ-014 SHALL have port tries_left  output  clog2(MAX_TRIES+1)  remaining attempts before lockout.

Function
REQ-015 States SHALL be ENTRY, ERROR, LOCKOUT, OPEN; registered state, one transition per cycle at most.
REQ-016 In ENTRY, enter SHALL store login against digit digit_cnt, set sticky mismatch if unequal, and increment digit_cnt.
REQ-017 Mismatch SHALL NOT be signalled before the N_DIGITS-th digit; no per-digit feedback.
REQ-018 On the N_DIGITS-th enter with no mismatch (including that digit), next state SHALL be OPEN, tries_left=MAX_TRIES, digit_cnt=0.
REQ-019 On the N_DIGITS-th enter with mismatch, tries_left SHALL decrement; next state SHALL be LOCKOUT if the result is 0, else ERROR; digit_cnt=0, mismatch cleared.
REQ-020 In ENTRY, oops SHALL clear digit_cnt and mismatch, stay in ENTRY, tries_left unchanged.
REQ-021 enter and oops in the same cycle: oops SHALL win; enter is discarded.
REQ-022 In ERROR, oops SHALL go to ENTRY; enter SHALL be ignored.
REQ-023 In LOCKOUT, enter and oops SHALL be ignored; a down-counter loaded with LOCKOUT_CYC-1 on entry SHALL decrement each cycle; the cycle it reads 0 the FSM SHALL go to ENTRY with tries_left=MAX_TRIES; LOCKOUT lasts exactly LOCKOUT_CYC cycles.
REQ-024 In OPEN, oops SHALL relock to ENTRY; enter SHALL be ignored.
REQ-025 flag, digit_cnt and tries_left SHALL update on the same edge as the state; output latency from input pulse is 1 cycle.
REQ-026 digit_cnt SHALL never exceed N_DIGITS-1 while observable in ENTRY; tries_left SHALL never underflow.

Reset
REQ-027 reset SHALL force state ENTRY, flag=4'b0001, digit_cnt=0, tries_left=MAX_TRIES, mismatch=0, lockout counter=0 at the next edge.
REQ-028 reset SHALL override all inputs and any state, including mid-entry and mid-LOCKOUT.

Structure
REQ-029 State encodings and flag bit positions SHALL live in shared package lock_pkg for reuse by board top and bench.
REQ-030 The lockout down-counter SHALL be one sub-module, lockout_timer (load, count, done pulse), parameterised by LOCKOUT_CYC.
REQ-031 LED dimming of flag SHALL remain outside this block (existing dimmer per bit at top level).

Verification (N_DIGITS=4, PASSCODE=16'h9317, MAX_TRIES=3, LOCKOUT_CYC=20)
REQ-032 Enter 9,3,1,7 -> flag=4'b1000 one cycle after 4th enter, tries_left=3; then oops -> flag=4'b0001.
REQ-033 Enter 9,3,1,6 -> flag stays 4'b0001 through digit 3, then 4'b0010, tries_left=2; enter ignored; oops -> ENTRY.
REQ-034 Three wrong codes -> flag=4'b0100, tries_left=0; held exactly 20 cycles despite enter/oops pulses; then flag=4'b0001, tries_left=3.
REQ-035 Enter 9,3 then oops -> digit_cnt=0, tries_left=3; then 9,3,1,7 -> OPEN.
REQ-036 enter+oops same cycle on digit 2 -> digit_cnt=0, no digit stored.
REQ-037 reset asserted at LOCKOUT cycle 10 and after 2 digits in ENTRY -> next edge flag=4'b0001, digit_cnt=0, tries_left=3.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state encodings and flag bit positions for the sequential code lock.
// Imported by the lock core, the board top and the bench.
package lock_pkg;

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_ERROR   = 2'd1,
      ST_LOCKOUT = 2'd2,
      ST_OPEN    = 2'd3
   } lock_state_t;

   localparam int FLAG_W       = 4;
   localparam int FLAG_ENTRY   = 0;
   localparam int FLAG_ERROR   = 1;
   localparam int FLAG_LOCKOUT = 2;
   localparam int FLAG_OPEN    = 3;

   // One-hot indication of a state; the LED dimmers sit on these bits.
   function automatic logic [FLAG_W-1:0] state_flag(input lock_state_t s);
      logic [FLAG_W-1:0] f;
      f = '0;
      case (s)
         ST_ENTRY:   f[FLAG_ENTRY]   = 1'b1;
         ST_ERROR:   f[FLAG_ERROR]   = 1'b1;
         ST_LOCKOUT: f[FLAG_LOCKOUT] = 1'b1;
         ST_OPEN:    f[FLAG_OPEN]    = 1'b1;
         default:    f[FLAG_ENTRY]   = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/lockout_timer.sv
// Lockout down-counter: loaded with LOCKOUT_CYC-1, counts while enabled,
// and pulses done during the enabled cycle in which it reads zero.
module lockout_timer #(
   parameter int LOCKOUT_CYC = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic count,
   output logic done
);

   localparam int CNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= LOAD_VAL;
      end else if (count && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign done = count && (cnt_reg == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Sequential code lock: digits are checked silently as they arrive and the
// verdict is only given after the last digit; repeated failures lock it out.
module seq_code_lock
   import lock_pkg::*;
#(
   parameter int DIGIT_W     = 4,
   parameter int N_DIGITS    = 4,
   parameter logic [DIGIT_W*N_DIGITS-1:0] PASSCODE = 16'h9317,
   parameter int MAX_TRIES   = 3,
   parameter int LOCKOUT_CYC = 100_000_000
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enter,
   input  logic                               oops,
   input  logic [DIGIT_W-1:0]                 login,
   output logic [DIGIT_W-1:0]                 loginled,
   output logic [FLAG_W-1:0]                  flag,
   output logic [$clog2(N_DIGITS+1)-1:0]      digit_cnt,
   output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

   localparam int CW = $clog2(N_DIGITS + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [CW-1:0] LAST_DIGIT = CW'(N_DIGITS - 1);
   localparam logic [TW-1:0] TRIES_FULL = TW'(MAX_TRIES);

   lock_state_t        state_reg, state_next;
   logic [FLAG_W-1:0]  flag_reg;
   logic [CW-1:0]      digit_cnt_reg, digit_cnt_next;
   logic [TW-1:0]      tries_reg, tries_next;
   logic               mismatch_reg, mismatch_next;
   logic               timer_load, timer_done;
   logic [N_DIGITS-1:0] digit_ok;
   logic               digit_hit;
   logic               code_bad;

   // Digit 0 lives in the most significant digit of PASSCODE.
   for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign digit_ok[gi] = (login == PASSCODE[DIGIT_W*(N_DIGITS-gi)-1 -: DIGIT_W]);
   end

   always_comb begin
      digit_hit = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (digit_cnt_reg == CW'(i)) begin
            digit_hit = digit_ok[i];
         end
      end
   end

   assign code_bad = mismatch_reg || !digit_hit;

   lockout_timer #(
      .LOCKOUT_CYC (LOCKOUT_CYC)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .count (state_reg == ST_LOCKOUT),
      .done  (timer_done)
   );

   always_comb begin
      state_next     = state_reg;
      digit_cnt_next = digit_cnt_reg;
      tries_next     = tries_reg;
      mismatch_next  = mismatch_reg;
      timer_load     = 1'b0;
      case (state_reg)
         ST_ENTRY: begin
            if (oops) begin
               digit_cnt_next = '0;
               mismatch_next  = 1'b0;
            end else if (enter) begin
               if (digit_cnt_reg == LAST_DIGIT) begin
                  digit_cnt_next = '0;
                  mismatch_next  = 1'b0;
                  if (!code_bad) begin
                     state_next = ST_OPEN;
                     tries_next = TRIES_FULL;
                  end else if (tries_reg <= TW'(1)) begin
                     // Last try used up: saturate at zero and start the timer.
                     state_next = ST_LOCKOUT;
                     tries_next = '0;
                     timer_load = 1'b1;
                  end else begin
                     state_next = ST_ERROR;
                     tries_next = tries_reg - TW'(1);
                  end
               end else begin
                  digit_cnt_next = digit_cnt_reg + CW'(1);
                  mismatch_next  = code_bad;
               end
            end
         end
         ST_ERROR: begin
            if (oops) begin
               state_next = ST_ENTRY;
            end
         end
         ST_LOCKOUT: begin
            if (timer_done) begin
               state_next = ST_ENTRY;
               tries_next = TRIES_FULL;
            end
         end
         ST_OPEN: begin
            if (oops) begin
               state_next = ST_ENTRY;
            end
         end
         default: begin
            state_next     = ST_ENTRY;
            digit_cnt_next = '0;
            mismatch_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_ENTRY;
         flag_reg      <= state_flag(ST_ENTRY);
         digit_cnt_reg <= '0;
         tries_reg     <= TRIES_FULL;
         mismatch_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         flag_reg      <= state_flag(state_next);
         digit_cnt_reg <= digit_cnt_next;
         tries_reg     <= tries_next;
         mismatch_reg  <= mismatch_next;
      end
   end

   assign loginled   = login;
   assign flag       = flag_reg;
   assign digit_cnt  = digit_cnt_reg;
   assign tries_left = tries_reg;

endmodule

// File: tb/tb_seq_code_lock.sv
// Bench for seq_code_lock: directed scenarios followed by random pulses, all
// checked against a digit-queue model of the lock's behaviour.
module tb_seq_code_lock;

   localparam int DIGIT_W     = 4;
   localparam int N_DIGITS    = 4;
   localparam logic [15:0] PASSCODE = 16'h9317;
   localparam int MAX_TRIES   = 3;
   localparam int LOCKOUT_CYC = 20;
   localparam int CW = $clog2(N_DIGITS + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);

   localparam int M_ENTRY = 0, M_ERROR = 1, M_LOCK = 2, M_OPEN = 3;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               enter = 1'b0;
   logic               oops = 1'b0;
   logic [DIGIT_W-1:0] login = '0;
   logic [DIGIT_W-1:0] loginled;
   logic [3:0]         flag;
   logic [CW-1:0]      digit_cnt;
   logic [TW-1:0]      tries_left;

   int n_checks = 0;
   int n_fail   = 0;

   int m_mode;
   int m_tries;
   int m_left;
   int q[$];

   seq_code_lock #(
      .DIGIT_W     (DIGIT_W),
      .N_DIGITS    (N_DIGITS),
      .PASSCODE    (PASSCODE),
      .MAX_TRIES   (MAX_TRIES),
      .LOCKOUT_CYC (LOCKOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enter      (enter),
      .oops       (oops),
      .login      (login),
      .loginled   (loginled),
      .flag       (flag),
      .digit_cnt  (digit_cnt),
      .tries_left (tries_left)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pass_digit(input int idx);
      return (int'(PASSCODE) >> (4 * (N_DIGITS - 1 - idx))) & 15;
   endfunction

   // Behavioural model: collect digits, judge the whole code once complete.
   task automatic model_step(input logic e, input logic o, input int d, input logic r);
      int val;
      if (r) begin
         m_mode = M_ENTRY; m_tries = MAX_TRIES; m_left = 0; q.delete();
      end else begin
         case (m_mode)
            M_ENTRY: begin
               if (o) q.delete();
               else if (e) begin
                  q.push_back(d);
                  if (q.size() == N_DIGITS) begin
                     val = 0;
                     foreach (q[i]) val = val * 16 + q[i];
                     q.delete();
                     if (val == int'(PASSCODE)) begin
                        m_mode = M_OPEN; m_tries = MAX_TRIES;
                     end else begin
                        m_tries--;
                        if (m_tries == 0) begin
                           m_mode = M_LOCK; m_left = LOCKOUT_CYC;
                        end else m_mode = M_ERROR;
                     end
                  end
               end
            end
            M_ERROR, M_OPEN: if (o) m_mode = M_ENTRY;
            M_LOCK: begin
               m_left--;
               if (m_left == 0) begin
                  m_mode = M_ENTRY; m_tries = MAX_TRIES;
               end
            end
            default: m_mode = M_ENTRY;
         endcase
      end
   endtask

   // One clock cycle with the given pulses; one line per transaction.
   task automatic tick(input logic e, input logic o, input logic [3:0] d, input logic r);
      enter = e; oops = o; login = d; reset = r;
      #1;
      check_eq("loginled", 32'(loginled), 32'(d));
      @(posedge clk);
      model_step(e, o, int'(d), r);
      #1;
      $display("cyc t=%0t rst=%0b ent=%0b oops=%0b d=%0h -> flag=%b cnt=%0d tries=%0d",
               $time, r, e, o, d, flag, digit_cnt, tries_left);
      check_eq("flag", 32'(flag), 32'(1 << m_mode));
      check_eq("onehot", 32'($onehot(flag)), 32'd1);
      check_eq("digit_cnt", 32'(digit_cnt), 32'(q.size()));
      check_eq("tries_left", 32'(tries_left), 32'(m_tries));
      enter = 1'b0; oops = 1'b0; reset = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] code);
      logic [15:0] c;
      c = code;
      for (int i = 0; i < N_DIGITS; i++) begin
         tick(1'b1, 1'b0, c[15:12], 1'b0);
         c = c << 4;
      end
   endtask

   task automatic do_reset();
      tick(1'b0, 1'b0, 4'h0, 1'b1);
      check_eq("reset_flag", 32'(flag), 32'h1);
      check_eq("reset_tries", 32'(tries_left), 32'd3);
      check_eq("reset_cnt", 32'(digit_cnt), 32'd0);
   endtask

   initial begin
      int n;
      int r;
      m_mode = M_ENTRY; m_tries = MAX_TRIES; m_left = 0;
      do_reset();
      do_reset();

      // Correct code opens, oops relocks.
      enter_code(16'h9317);
      check_eq("open_flag", 32'(flag), 32'h8);
      check_eq("open_tries", 32'(tries_left), 32'd3);
      tick(1'b0, 1'b1, 4'h0, 1'b0);
      check_eq("relock_flag", 32'(flag), 32'h1);

      // Wrong last digit: no feedback until the 4th digit.
      do_reset();
      tick(1'b1, 1'b0, 4'h9, 1'b0);
      tick(1'b1, 1'b0, 4'h3, 1'b0);
      tick(1'b1, 1'b0, 4'h1, 1'b0);
      check_eq("no_early_err", 32'(flag), 32'h1);
      tick(1'b1, 1'b0, 4'h6, 1'b0);
      check_eq("err_flag", 32'(flag), 32'h2);
      check_eq("err_tries", 32'(tries_left), 32'd2);
      tick(1'b1, 1'b0, 4'h9, 1'b0);
      check_eq("err_ignores_enter", 32'(flag), 32'h2);
      tick(1'b0, 1'b1, 4'h0, 1'b0);
      check_eq("err_oops", 32'(flag), 32'h1);

      // Wrong first digit must still fail even though later digits match.
      do_reset();
      enter_code(16'h0317);
      check_eq("err_first_digit", 32'(flag), 32'h2);

      // Partial entry cleared by oops.
      do_reset();
      tick(1'b1, 1'b0, 4'h9, 1'b0);
      tick(1'b1, 1'b0, 4'h3, 1'b0);
      tick(1'b0, 1'b1, 4'h0, 1'b0);
      check_eq("oops_cnt", 32'(digit_cnt), 32'd0);
      check_eq("oops_tries", 32'(tries_left), 32'd3);
      enter_code(16'h9317);
      check_eq("after_oops_open", 32'(flag), 32'h8);

      // enter+oops together on digit 2: oops wins, nothing stored.
      do_reset();
      tick(1'b1, 1'b0, 4'h9, 1'b0);
      tick(1'b1, 1'b1, 4'h3, 1'b0);
      check_eq("both_cnt", 32'(digit_cnt), 32'd0);
      enter_code(16'h9317);
      check_eq("both_then_open", 32'(flag), 32'h8);

      // Three failures -> lockout lasting exactly LOCKOUT_CYC cycles.
      do_reset();
      for (int k = 0; k < MAX_TRIES; k++) begin
         enter_code(16'h0000);
         if (k < MAX_TRIES - 1) tick(1'b0, 1'b1, 4'h0, 1'b0);
      end
      check_eq("lock_flag", 32'(flag), 32'h4);
      check_eq("lock_tries", 32'(tries_left), 32'd0);
      n = 1;
      while (flag == 4'h4 && n < 100) begin
         tick(n[0], !n[0], 4'h9, 1'b0);
         if (flag == 4'h4) n++;
      end
      check_eq("lock_len", 32'(n), 32'(LOCKOUT_CYC));
      check_eq("unlock_flag", 32'(flag), 32'h1);
      check_eq("unlock_tries", 32'(tries_left), 32'd3);

      // Reset in the middle of lockout and in the middle of entry.
      for (int k = 0; k < MAX_TRIES; k++) begin
         enter_code(16'h1111);
         if (k < MAX_TRIES - 1) tick(1'b0, 1'b1, 4'h0, 1'b0);
      end
      for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 4'h0, 1'b0);
      check_eq("mid_lock", 32'(flag), 32'h4);
      do_reset();
      tick(1'b1, 1'b0, 4'h9, 1'b0);
      tick(1'b1, 1'b0, 4'h3, 1'b0);
      check_eq("mid_entry_cnt", 32'(digit_cnt), 32'd2);
      tick(1'b1, 1'b1, 4'h1, 1'b1);
      check_eq("rst_entry_cnt", 32'(digit_cnt), 32'd0);
      check_eq("rst_entry_flag", 32'(flag), 32'h1);

      // Random pulses, biased toward correct digits so OPEN is reached.
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         if (r < 1)       tick(1'b0, 1'b0, 4'h0, 1'b1);
         else if (r < 40) tick(1'b0, 1'b0, 4'($urandom), 1'b0);
         else if (r < 80) tick(1'b1, 1'b0, 4'(pass_digit(q.size() % N_DIGITS)), 1'b0);
         else if (r < 90) tick(1'b1, 1'b0, 4'($urandom), 1'b0);
         else if (r < 97) tick(1'b0, 1'b1, 4'($urandom), 1'b0);
         else             tick(1'b1, 1'b1, 4'($urandom), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
